button_debounce_sched: RTL and testbench

Time-multiplexed debounce controller: one shared settle counter serves NUM_BTN push-button inputs, scheduled round-robin. It sits between the board button pins and the user-interface logic. It provides a debounced level per button and a valid/ready event stream of qualified press (and optionally release) transitions.

---
 rtl/button_debounce_sched.sv | 151 +++++++++++++++
 tb/tb_button_debounce_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_sched.sv
// Round-robin debounce scheduler: a single settle counter qualifies one pending button at a time.
// Optional macro DBSCHED_RELEASE_EVT_EN also reports release (1->0) commits as events.
module button_debounce_sched #(
    parameter int NUM_BTN     = 4,
    parameter int IDX_W       = 2,
    parameter int SETTLE_LOG2 = 10
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] db_out,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_idx,
    output logic               evt_press,
    output logic               sched_busy
);

    typedef enum logic [1:0] {IDLE, QUAL, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_BTN-1:0]     sync1_q, sync2_q;
    logic [NUM_BTN-1:0]     db_q, db_d;
    logic [SETTLE_LOG2-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d, cur_q, cur_d;
    logic                   valid_q, valid_d, press_q, press_d, busy_q, busy_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic [NUM_BTN-1:0]     pending, rot, cur_oh;
    logic                   found, cur_sync, cur_db, report;
    logic [IDX_W-1:0]       sel, sel_nxt;
    int                     j;

    assign pending = sync2_q ^ db_q;

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        press_d = press_q;
        found   = 1'b0;
        sel     = '0;
        j       = 0;
        cur_oh  = '0;
        cur_sync = 1'b0;
        cur_db   = 1'b0;

        // Rotate so bit 0 is the button at ptr; first set bit wins.
        rot = NUM_BTN'({pending, pending} >> ptr_q);
        for (int k = 0; k < NUM_BTN; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                j = int'(ptr_q) + k;
                if (j >= NUM_BTN) j = j - NUM_BTN;
                sel = IDX_W'(j);
            end
        end
        sel_nxt = (int'(sel) == NUM_BTN - 1) ? '0 : sel + 1'b1;

        for (int i = 0; i < NUM_BTN; i++) begin
            if (cur_q == IDX_W'(i)) begin
                cur_oh[i] = 1'b1;
                cur_sync  = sync2_q[i];
                cur_db    = db_q[i];
            end
        end

`ifdef DBSCHED_RELEASE_EVT_EN
        report = 1'b1;
`else
        report = cur_sync;
`endif

        case (state_q)
            IDLE: begin
                if (found) begin
                    cur_d   = sel;
                    cnt_d   = '0;
                    ptr_d   = sel_nxt;
                    state_d = QUAL;
                end
            end
            QUAL: begin
                if (cur_sync == cur_db) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (&cnt_q) begin
                    db_d = db_q ^ cur_oh;
                    if (report) begin
                        valid_d = 1'b1;
                        idx_d   = cur_q;
                        press_d = cur_sync;
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            cur_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            press_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            press_q <= press_d;
            busy_q  <= busy_d;
        end
    end

    assign db_out     = db_q;
    assign evt_valid  = valid_q;
    assign evt_idx    = idx_q;
    assign evt_press  = press_q;
    assign sched_busy = busy_q;

endmodule

// File: tb/tb_button_debounce_sched.sv
// Bench for button_debounce_sched: directed scenarios plus random bouncy inputs,
// checked every cycle against a timestamp-based reference model.
module tb_button_debounce_sched;

    localparam int N = 4, IW = 2, SL = 3, SETTLE = 8;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [N-1:0]  btn_in = '0;
    logic          evt_ready = 1'b1;
    logic [N-1:0]  db_out;
    logic          evt_valid, evt_press, sched_busy;
    logic [IW-1:0] evt_idx;

    always #5 clk = ~clk;

    button_debounce_sched #(.NUM_BTN(N), .IDX_W(IW), .SETTLE_LOG2(SL)) dut (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_in), .db_out(db_out),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
        .evt_press(evt_press), .sched_busy(sched_busy)
    );

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 qualifying (started at cycle m_t), 2 holding an event.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_pend;
    int   m_mode = 0, m_cur = 0, m_ptr = 0, m_t = 0, m_idx = 0, cyc = 0;
    logic m_valid = 1'b0, m_press = 1'b0;
    bit   m_found;

    always @(posedge clk) begin
        if (!n_reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            m_mode = 0; m_cur = 0; m_ptr = 0; m_idx = 0;
            m_valid = 1'b0; m_press = 1'b0;
        end else begin
            m_pend = m_s2 ^ m_db;
            if (m_mode == 0) begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && m_pend[(m_ptr + k) % N]) begin
                        m_found = 1'b1;
                        m_cur  = (m_ptr + k) % N;
                        m_ptr  = (m_cur + 1) % N;
                        m_t    = cyc;
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (m_s2[m_cur] == m_db[m_cur]) m_mode = 0;
                else if (cyc - m_t == SETTLE) begin
                    m_db[m_cur] = m_s2[m_cur];
`ifdef DBSCHED_RELEASE_EVT_EN
                    m_valid = 1'b1; m_idx = m_cur; m_press = m_s2[m_cur]; m_mode = 2;
`else
                    if (m_s2[m_cur]) begin
                        m_valid = 1'b1; m_idx = m_cur; m_press = 1'b1; m_mode = 2;
                    end else m_mode = 0;
`endif
                end
            end else if (evt_ready) begin
                m_valid = 1'b0;
                m_mode = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("db_out", 32'(db_out), 32'(m_db));
            chk("evt_valid", 32'(evt_valid), 32'(m_valid));
            chk("sched_busy", 32'(sched_busy), 32'(m_mode != 0));
            if (m_valid) begin
                chk("evt_idx", 32'(evt_idx), 32'(m_idx));
                chk("evt_press", 32'(evt_press), 32'(m_press));
            end
        end
    end

    task automatic do_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic wait_db(input int b, input logic lvl, input int maxc, output int n);
        n = maxc + 1;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk); @(negedge clk);
            if (db_out[b] === lvl) begin n = c; return; end
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = maxc + 1;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk); @(negedge clk);
            if (evt_valid === 1'b1) begin n = c; return; end
        end
    endtask

    // Records up to two events over a fixed window; assumes evt_ready held high.
    task automatic collect(output int ne, output int i0, output int i1, output int gap);
        int c0;
        ne = 0; i0 = -1; i1 = -1; gap = 0; c0 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) begin
                if (ne == 0) begin i0 = int'(evt_idx); c0 = c; end
                else if (ne == 1) begin i1 = int'(evt_idx); gap = c - c0; end
                ne++;
            end
        end
    endtask

    int n, ne, i0, i1, gap;
    bit saw;
    int hold[N];

    initial begin
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        chk_en  = 1'b1;
        chk("rst_db", 32'(db_out), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_idx", 32'(evt_idx), 0);
        chk("rst_press", 32'(evt_press), 0);
        chk("rst_busy", 32'(sched_busy), 0);

        // Short glitch on button 0 must never commit.
        btn_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        btn_in[0] = 1'b0;
        saw = 1'b0;
        repeat (25) begin @(negedge clk); if (evt_valid === 1'b1) saw = 1'b1; end
        chk("bounce_evt", 32'(saw), 0);
        chk("bounce_db", 32'(db_out), 0);
        chk("bounce_busy", 32'(sched_busy), 0);

        btn_in[2] = 1'b1;
        wait_db(2, 1'b1, 40, n);
        chk("press_latency", n, SETTLE + 3);
        chk("press_valid", 32'(evt_valid), 1);
        chk("press_idx", 32'(evt_idx), 2);
        chk("press_dir", 32'(evt_press), 1);
        @(negedge clk);
        chk("press_pulse", 32'(evt_valid), 0);

        btn_in[2] = 1'b0;
        wait_db(2, 1'b0, 40, n);
        chk("rel_latency", n, SETTLE + 3);
`ifdef DBSCHED_RELEASE_EVT_EN
        chk("rel_valid", 32'(evt_valid), 1);
        chk("rel_idx", 32'(evt_idx), 2);
        chk("rel_dir", 32'(evt_press), 0);
`else
        chk("rel_valid", 32'(evt_valid), 0);
`endif
        repeat (3) @(negedge clk);

        // Simultaneous press with ptr at 0.
        do_reset();
        btn_in = 4'b1010;
        collect(ne, i0, i1, gap);
        chk("rr0_count", ne, 2);
        chk("rr0_first", i0, 1);
        chk("rr0_second", i1, 3);
        chk("rr0_gap", 32'(gap >= SETTLE), 1);

        // Steer ptr to 2 by qualifying button 1 twice, then repeat.
        btn_in = '0;
        do_reset();
        btn_in = 4'b0010;
        wait_db(1, 1'b1, 40, n);
        chk("rr2_setup_press", n, SETTLE + 3);
        btn_in = 4'b0000;
        wait_db(1, 1'b0, 40, n);
        chk("rr2_setup_rel", n, SETTLE + 3);
        repeat (2) @(negedge clk);
        btn_in = 4'b1010;
        collect(ne, i0, i1, gap);
        chk("rr2_count", ne, 2);
        chk("rr2_first", i0, 3);
        chk("rr2_second", i1, 1);

        // Backpressure: event for button 0 held while button 1 waits.
        btn_in = '0;
        do_reset();
        evt_ready = 1'b0;
        btn_in = 4'b0011;
        wait_valid(40, n);
        chk("bp_first_latency", n, SETTLE + 3);
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(evt_valid), 1);
            chk("bp_idx_hold", 32'(evt_idx), 0);
            chk("bp_press_hold", 32'(evt_press), 1);
            chk("bp_db1_wait", 32'(db_out[1]), 0);
        end
        evt_ready = 1'b1;
        wait_db(1, 1'b1, 40, n);
        chk("bp_after_accept", n, SETTLE + 2);
        repeat (3) @(negedge clk);

        // Reset while qualifying at cnt=5, button kept pressed.
        btn_in = '0;
        do_reset();
        btn_in = 4'b0100;
        repeat (8) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        chk("midrst_db", 32'(db_out), 0);
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_busy", 32'(sched_busy), 0);
        n_reset = 1'b1;
        wait_valid(40, n);
        chk("midrst_relatency", n, SETTLE + 3);
        chk("midrst_idx", 32'(evt_idx), 2);

        // Random bouncy buttons, random backpressure, rare resets.
        btn_in = '0;
        do_reset();
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn_in[i] = ~btn_in[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                           : int'($urandom_range(10, 40));
                end else hold[i]--;
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            n_reset   = ($urandom_range(0, 599) != 0);
        end
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
